// File: rtl/div_io_pkg.sv
// Shared definitions for the divider's byte-serial I/O wrappers.
// Holds the wrapper FSM state encoding and the byte-lane ordering used on
// the 8-bit bus, so the input and output sides agree on byte order.
//   idx0 = dividend high byte, idx1 = dividend low byte,
//   idx2 = divisor high byte,  idx3 = divisor low byte.
package div_io_pkg;

  localparam int BYTE_IDX_W = 2;
  localparam int NUM_BYTES  = 1 << BYTE_IDX_W;

  typedef logic [BYTE_IDX_W-1:0] byte_idx_t;

  localparam byte_idx_t IDX_DVD_HI = 2'd0;
  localparam byte_idx_t IDX_DVD_LO = 2'd1;
  localparam byte_idx_t IDX_DVS_HI = 2'd2;
  localparam byte_idx_t IDX_DVS_LO = 2'd3;

  typedef enum logic [1:0] {
    S_COLLECT = 2'd0,
    S_CHECK   = 2'd1,
    S_START   = 2'd2,
    S_WAIT    = 2'd3
  } state_t;

  // True when the given slot is the final byte of a transaction.
  function automatic logic is_last_idx(input byte_idx_t idx);
    return idx == IDX_DVS_LO;
  endfunction

endpackage

// File: rtl/input_wrapper_if.sv
// Byte-wide valid/ready input bus.
//   in_valid : sender has a byte on in_data this cycle
//   in_data  : the byte
//   in_ready : receiver accepts a byte this cycle
// master = byte sender, slave = byte receiver (the input wrapper).
interface input_wrapper_if #(
  parameter int BUS_W = 8
);
  logic             in_valid;
  logic [BUS_W-1:0] in_data;
  logic             in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/input_wrapper_dp.sv
// Datapath of the input wrapper: byte counter with carry, byte-slot write
// decoder, operand registers and the divisor==0 compare.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   ld_byte         write din into the slot selected by the counter, count up
//   inz_cnt         clear the counter (wins over ld_byte, no slot write)
//   din             incoming byte
//   dividend/divisor assembled operands (registered)
//   co              the byte being loaded this cycle is the last one
//   dvs_zero        the registered divisor is zero
module input_wrapper_dp
  import div_io_pkg::*;
#(
  parameter int BUS_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_byte,
  input  logic              inz_cnt,
  input  logic [BUS_W-1:0]  din,
  output logic [DATA_W-1:0] dividend,
  output logic [DATA_W-1:0] divisor,
  output logic              co,
  output logic              dvs_zero
);

  if (DATA_W != 2 * BUS_W) begin : g_bad_width
    $error("input_wrapper_dp: DATA_W must be 2*BUS_W");
  end

  byte_idx_t cnt_reg;
  byte_idx_t cnt_next;
  logic      load_en;

  // A clear in the same cycle discards the byte entirely.
  assign load_en = ld_byte && !inz_cnt;

  always_comb begin
    cnt_next = cnt_reg;
    if (inz_cnt) begin
      cnt_next = '0;
    end else if (ld_byte) begin
      cnt_next = cnt_reg + byte_idx_t'(1);  // wraps 3 -> 0 on the last byte
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign co = load_en && is_last_idx(cnt_reg);

  // One byte register per bus slot, written when the counter selects it.
  for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_slot
    logic             wr_en;
    logic [BUS_W-1:0] slot_reg;

    assign wr_en = load_en && (cnt_reg == byte_idx_t'(gi));

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        slot_reg <= '0;
      end else if (wr_en) begin
        slot_reg <= din;
      end
    end
  end

  assign dividend = {g_slot[IDX_DVD_HI].slot_reg, g_slot[IDX_DVD_LO].slot_reg};
  assign divisor  = {g_slot[IDX_DVS_HI].slot_reg, g_slot[IDX_DVS_LO].slot_reg};
  assign dvs_zero = (divisor == '0);

endmodule

// File: rtl/input_wrapper.sv
// Input-side byte deserializer for the divider core.
// Collects four bytes (dividend hi/lo, divisor hi/lo) from a valid/ready bus,
// then either rejects a zero divisor (div_zero pulse) or pulses div_start and
// blocks further input until the core reports div_done.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   soft_clr   synchronous abort of a partial/in-flight transaction
//   in_bus     byte input bus (slave side)
//   div_done   divider finished (pulse or level), only observed in S_WAIT
//   dividend   assembled dividend, registered
//   divisor    assembled divisor, registered
//   div_start  one-cycle start pulse to the core
//   div_zero   one-cycle pulse when the divisor is zero
//   busy       transaction in flight (S_START or S_WAIT)
module input_wrapper
  import div_io_pkg::*;
#(
  parameter int BUS_W  = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              soft_clr,
  input_wrapper_if.slave    in_bus,
  input  logic              div_done,
  output logic [DATA_W-1:0] dividend,
  output logic [DATA_W-1:0] divisor,
  output logic              div_start,
  output logic              div_zero,
  output logic              busy
);

  state_t state_reg;
  state_t state_next;

  logic accept;
  logic ld_byte;
  logic inz_cnt;
  logic co;
  logic dvs_zero;

  // Moore decode: bytes are only taken while collecting.
  assign in_bus.in_ready = (state_reg == S_COLLECT);
  assign accept          = in_bus.in_valid && in_bus.in_ready;

  // soft_clr drops a byte offered in the same cycle.
  assign ld_byte = accept && !soft_clr;
  assign inz_cnt = soft_clr;

  input_wrapper_dp #(
    .BUS_W (BUS_W),
    .DATA_W(DATA_W)
  ) u_dp (
    .clk     (clk),
    .rst     (rst),
    .ld_byte (ld_byte),
    .inz_cnt (inz_cnt),
    .din     (in_bus.in_data),
    .dividend(dividend),
    .divisor (divisor),
    .co      (co),
    .dvs_zero(dvs_zero)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= S_COLLECT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_COLLECT: begin
        if (co) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        state_next = dvs_zero ? S_COLLECT : S_START;
      end
      S_START: begin
        // div_done here belongs to no transaction of ours; ignore it.
        state_next = S_WAIT;
      end
      S_WAIT: begin
        if (div_done) begin
          state_next = S_COLLECT;
        end
      end
      default: begin
        state_next = S_COLLECT;
      end
    endcase
    if (soft_clr) begin
      state_next = S_COLLECT;
    end
  end

  assign div_start = (state_reg == S_START);
  // dvs_zero comes from registered operands, so this is still state-decoded.
  assign div_zero  = (state_reg == S_CHECK) && dvs_zero;
  assign busy      = (state_reg == S_START) || (state_reg == S_WAIT);

endmodule

// File: tb/tb_input_wrapper.sv
module tb_input_wrapper;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        soft_clr = 1'b0;
  logic        div_done = 1'b0;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic        div_start;
  logic        div_zero;
  logic        busy;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int zero_cnt = 0;

  input_wrapper_if #(.BUS_W(8)) bus ();

  input_wrapper #(
    .BUS_W (8),
    .DATA_W(16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .soft_clr (soft_clr),
    .in_bus   (bus),
    .div_done (div_done),
    .dividend (dividend),
    .divisor  (divisor),
    .div_start(div_start),
    .div_zero (div_zero),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Count pulses as seen by the edge that consumes them.
  always @(posedge clk) begin
    if (div_start === 1'b1) start_cnt++;
    if (div_zero === 1'b1) zero_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] bytes;
    int          gap;
    logic [15:0] exp_dvd;
    logic [15:0] exp_dvs;
    bit          exp_zero;
    bit          junk_in_wait;
    bit          early_done;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte and hold it until accepted; returns #1 after the accept edge.
  task automatic send_byte(input logic [7:0] b);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    for (int k = 0; k < 50 && !done; k++) begin
      if (bus.in_ready === 1'b1) done = 1'b1;
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=%0b required 1", bus.in_ready);
    end
  endtask

  task automatic run_txn(input string tag, input vec_t v);
    int s0 = start_cnt;
    int z0 = zero_cnt;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) repeat (v.gap) step();
      send_byte(v.bytes[31-8*i -: 8]);
    end
    // S_CHECK cycle
    chk({tag, "_chk_ready"}, 32'(bus.in_ready), 0);
    chk({tag, "_chk_start"}, 32'(div_start), 0);
    chk({tag, "_chk_zero"}, 32'(div_zero), 32'(v.exp_zero));
    chk({tag, "_dividend"}, 32'(dividend), 32'(v.exp_dvd));
    chk({tag, "_divisor"}, 32'(divisor), 32'(v.exp_dvs));
    step();
    if (v.exp_zero) begin
      chk({tag, "_z_ready"}, 32'(bus.in_ready), 1);
      chk({tag, "_z_busy"}, 32'(busy), 0);
      chk({tag, "_z_zero_off"}, 32'(div_zero), 0);
      chk({tag, "_z_nstart"}, 32'(start_cnt - s0), 0);
      chk({tag, "_z_nzero"}, 32'(zero_cnt - z0), 1);
    end else begin
      chk({tag, "_st_start"}, 32'(div_start), 1);
      chk({tag, "_st_busy"}, 32'(busy), 1);
      chk({tag, "_st_ready"}, 32'(bus.in_ready), 0);
      if (v.early_done) div_done = 1'b1;
      step();
      div_done = 1'b0;
      chk({tag, "_w_start"}, 32'(div_start), 0);
      chk({tag, "_w_busy"}, 32'(busy), 1);
      chk({tag, "_w_ready"}, 32'(bus.in_ready), 0);
      if (v.junk_in_wait) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
      end
      repeat (3) step();
      chk({tag, "_w_busy_hold"}, 32'(busy), 1);
      bus.in_valid = 1'b0;
      div_done = 1'b1;
      step();
      div_done = 1'b0;
      chk({tag, "_d_ready"}, 32'(bus.in_ready), 1);
      chk({tag, "_d_busy"}, 32'(busy), 0);
      chk({tag, "_d_dividend"}, 32'(dividend), 32'(v.exp_dvd));
      chk({tag, "_d_divisor"}, 32'(divisor), 32'(v.exp_dvs));
      chk({tag, "_nstart"}, 32'(start_cnt - s0), 1);
      chk({tag, "_nzero"}, 32'(zero_cnt - z0), 0);
    end
    $display("txn %s: dividend=%04h divisor=%04h starts=%0d zeros=%0d",
             tag, dividend, divisor, start_cnt - s0, zero_cnt - z0);
  endtask

  vec_t vecs[5];
  vec_t v;
  int s_before;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    //            bytes          gap dvd      dvs      zero junk early
    vecs[0] = '{32'h12340056, 0, 16'h1234, 16'h0056, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF0002, 3, 16'hFFFF, 16'h0002, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{32'h00100000, 0, 16'h0010, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h01020304, 1, 16'h0102, 16'h0304, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h00640005, 0, 16'h0064, 16'h0005, 1'b0, 1'b0, 1'b1};

    // Reset state
    #12;
    chk("rst_ready", 32'(bus.in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_start", 32'(div_start), 0);
    chk("rst_zero", 32'(div_zero), 0);
    chk("rst_dividend", 32'(dividend), 0);
    chk("rst_divisor", 32'(divisor), 0);
    @(negedge clk);
    rst = 1'b1;
    step();

    // Table-driven transactions, back to back
    for (int i = 0; i < 5; i++) begin
      run_txn($sformatf("v%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of a transaction
    send_byte(8'hAB);
    send_byte(8'hCD);
    chk("mid_partial_dvd", 32'(dividend), 32'h0000ABCD);
    #2;
    rst = 1'b0;
    #2;
    chk("mid_rst_dividend", 32'(dividend), 0);
    chk("mid_rst_divisor", 32'(divisor), 0);
    chk("mid_rst_ready", 32'(bus.in_ready), 1);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_start", 32'(div_start), 0);
    @(negedge clk);
    rst = 1'b1;
    step();
    v = '{32'h00090003, 0, 16'h0009, 16'h0003, 1'b0, 1'b0, 1'b0};
    run_txn("after_rst", v);

    // soft_clr together with the 4th byte
    s_before = start_cnt;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h44;
    soft_clr     = 1'b1;
    step();
    soft_clr     = 1'b0;
    bus.in_valid = 1'b0;
    chk("sclr_ready", 32'(bus.in_ready), 1);
    chk("sclr_busy", 32'(busy), 0);
    chk("sclr_zero", 32'(div_zero), 0);
    chk("sclr_dividend_kept", 32'(dividend), 32'h00001122);
    repeat (2) step();
    chk("sclr_nstart", 32'(start_cnt - s_before), 0);
    chk("sclr_busy_later", 32'(busy), 0);
    v = '{32'h01000010, 0, 16'h0100, 16'h0010, 1'b0, 1'b0, 1'b0};
    run_txn("after_sclr", v);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
